// File: rtl/riscv_next_pkg.sv
// Shared types and constants for the riscv_next BTB jump-prediction strategy.
// RISCV_NEXT_BTB_COUNTER_EN adds 2-bit saturating confidence counters to each entry.
package riscv_next_pkg;

   localparam int BTB_ADDR_WIDTH_DEF = 16;
   localparam int BTB_ENTRIES_DEF    = 32;

   localparam logic [1:0] BTB_CTR_INIT = 2'd2;
   localparam logic [1:0] BTB_CTR_MAX  = 2'd3;

   function automatic int btb_idx_w(input int entries);
      return $clog2(entries);
   endfunction

   // Word-aligned PCs: bits [1:0] are dropped, the index sits just above them.
   function automatic int btb_tag_w(input int addr_w, input int entries);
      return addr_w - $clog2(entries) - 2;
   endfunction

   function automatic int btb_target_w(input int addr_w);
      return addr_w;
   endfunction

   typedef enum logic {
      BTB_IDLE,
      BTB_SWEEP
   } btb_state_t;

   typedef struct packed {
      logic                                                      valid;
      logic [btb_tag_w(BTB_ADDR_WIDTH_DEF, BTB_ENTRIES_DEF)-1:0] tag;
      logic [btb_target_w(BTB_ADDR_WIDTH_DEF)-1:0]               target;
`ifdef RISCV_NEXT_BTB_COUNTER_EN
      logic [1:0]                                                ctr;
`endif
   } btb_entry_t;

endpackage

// File: rtl/riscv_next_btb_sat2.sv
// 2-bit saturating up/down counter, purely combinational next-value.
// Only instantiated when RISCV_NEXT_BTB_COUNTER_EN is defined.
module riscv_next_btb_sat2
   import riscv_next_pkg::*;
(
   input  logic [1:0] i_ctr,
   input  logic       i_up,
   output logic [1:0] o_ctr
);

   always_comb begin
      // NOTE: defaulting every always_comb output first keeps partial branches from inferring a latch.
      o_ctr = i_ctr;
      if (i_up) begin
         if (i_ctr != BTB_CTR_MAX) o_ctr = i_ctr + 2'd1;
      end else if (i_ctr != 2'd0) begin
         o_ctr = i_ctr - 2'd1;
      end
   end

endmodule

// File: rtl/riscv_next_btb_strategy.sv
// Direct-mapped tagged BTB injecting predicted targets at the PM stage, with sweep invalidate.
// RISCV_NEXT_BTB_COUNTER_EN enables 2-bit confidence counters; otherwise a hit alone predicts taken.
module riscv_next_btb_strategy
   import riscv_next_pkg::*;
#(
   parameter int ADDR_WIDTH = BTB_ADDR_WIDTH_DEF,
   parameter int ENTRIES    = BTB_ENTRIES_DEF
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [ADDR_WIDTH-1:0] i_pm_pc,
   input  logic                  i_pm_flush,
   output logic                  o_inject,
   output logic [ADDR_WIDTH-1:0] o_inject_addr,
   input  logic                  i_hist_valid,
   input  logic [ADDR_WIDTH-1:0] i_hist_pc,
   input  logic                  i_hist_flush,
   input  logic                  i_hist_taken,
   input  logic [ADDR_WIDTH-1:0] i_hist_target,
   input  logic                  i_invalidate,
   output logic                  o_busy
);

   localparam int IDX_W = btb_idx_w(ENTRIES);
   localparam int TAG_W = btb_tag_w(ADDR_WIDTH, ENTRIES);

   if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0 || IDX_W + 2 >= ADDR_WIDTH) begin : g_bad_cfg
      $error("riscv_next_btb_strategy: ENTRIES must be a power of two >= 2 with IDX_W+2 < ADDR_WIDTH");
   end

   typedef struct packed {
      logic                  valid;
      logic [TAG_W-1:0]      tag;
      logic [ADDR_WIDTH-1:0] target;
`ifdef RISCV_NEXT_BTB_COUNTER_EN
      logic [1:0]            ctr;
`endif
   } entry_t;

   entry_t           btb_q [ENTRIES];
   btb_state_t       state_q, state_d;
   logic [IDX_W-1:0] sweep_idx_q, sweep_idx_d;

   logic unused_pc_bits;
   assign unused_pc_bits = ^{i_pm_pc[1:0], i_hist_pc[1:0]};

   assign o_busy = i_rst || (state_q == BTB_SWEEP);

   // Lookup path
   logic [IDX_W-1:0] pm_idx;
   logic [TAG_W-1:0] pm_tag;
   entry_t           pm_ent;
   logic             pm_hit;

   assign pm_idx = i_pm_pc[IDX_W+1:2];
   assign pm_tag = i_pm_pc[ADDR_WIDTH-1:IDX_W+2];
   assign pm_ent = btb_q[pm_idx];

`ifdef RISCV_NEXT_BTB_COUNTER_EN
   assign pm_hit = pm_ent.valid && (pm_ent.tag == pm_tag) && pm_ent.ctr[1];
`else
   assign pm_hit = pm_ent.valid && (pm_ent.tag == pm_tag);
`endif

   assign o_inject      = !o_busy && !i_pm_flush && pm_hit;
   assign o_inject_addr = o_inject ? pm_ent.target : '0;

   // Training path
   logic [IDX_W-1:0] hist_idx;
   logic [TAG_W-1:0] hist_tag;
   entry_t           hist_ent, upd_ent;
   logic             hist_hit, upd_en, upd_we;

   assign hist_idx = i_hist_pc[IDX_W+1:2];
   assign hist_tag = i_hist_pc[ADDR_WIDTH-1:IDX_W+2];
   assign hist_ent = btb_q[hist_idx];
   assign hist_hit = hist_ent.valid && (hist_ent.tag == hist_tag);
   assign upd_en   = i_hist_valid && !i_hist_flush && !o_busy;

`ifdef RISCV_NEXT_BTB_COUNTER_EN
   logic [1:0] ctr_next;

   riscv_next_btb_sat2 u_sat2 (
      .i_ctr (hist_ent.ctr),
      .i_up  (i_hist_taken),
      .o_ctr (ctr_next)
   );
`endif

   always_comb begin
      upd_we  = 1'b0;
      upd_ent = hist_ent;
      if (upd_en) begin
`ifdef RISCV_NEXT_BTB_COUNTER_EN
         if (hist_hit) begin
            upd_we      = 1'b1;
            upd_ent.ctr = ctr_next;
            if (i_hist_taken) upd_ent.target = i_hist_target;
         end else if (i_hist_taken) begin
            upd_we         = 1'b1;
            upd_ent.valid  = 1'b1;
            upd_ent.tag    = hist_tag;
            upd_ent.target = i_hist_target;
            upd_ent.ctr    = BTB_CTR_INIT;
         end
`else
         if (i_hist_taken) begin
            upd_we         = 1'b1;
            upd_ent.valid  = 1'b1;
            upd_ent.tag    = hist_tag;
            upd_ent.target = i_hist_target;
         end else if (hist_hit) begin
            upd_we        = 1'b1;
            upd_ent.valid = 1'b0;
         end
`endif
      end
   end

   // Single write port: sweep owns it while busy, training updates are dropped then.
   // NOTE: the table array has no reset; valid bits are cleared by the sweep that reset starts,
   // and lookups/updates are masked by o_busy until it completes.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         if (state_q == BTB_SWEEP) begin
            btb_q[sweep_idx_q].valid <= 1'b0;
         end else if (upd_we) begin
            btb_q[hist_idx] <= upd_ent;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= BTB_SWEEP;
         sweep_idx_q <= '0;
      end else begin
         state_q     <= state_d;
         sweep_idx_q <= sweep_idx_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      sweep_idx_d = sweep_idx_q;
      case (state_q)
         BTB_IDLE: begin
            if (i_invalidate) begin
               state_d     = BTB_SWEEP;
               sweep_idx_d = '0;
            end
         end
         BTB_SWEEP: begin
            if (i_invalidate) begin
               sweep_idx_d = '0;
            end else if (sweep_idx_q == IDX_W'(ENTRIES - 1)) begin
               state_d     = BTB_IDLE;
               sweep_idx_d = '0;
            end else begin
               sweep_idx_d = sweep_idx_q + 1'b1;
            end
         end
         default: begin
            state_d     = BTB_SWEEP;
            sweep_idx_d = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_riscv_next_btb_strategy.sv
// Scoreboard bench for riscv_next_btb_strategy: a behavioural table model predicts each cycle's outputs.
// Follows RISCV_NEXT_BTB_COUNTER_EN so it matches whichever build it is compiled with.
module tb_riscv_next_btb_strategy;

   localparam int AW = 16;
   localparam int N  = 32;

   typedef struct packed {
      logic          busy;
      logic          inj;
      logic [AW-1:0] addr;
   } exp_t;

   logic          clk;
   logic          rst;
   logic [AW-1:0] pm_pc;
   logic          pm_flush;
   logic          inject;
   logic [AW-1:0] inject_addr;
   logic          hist_valid;
   logic [AW-1:0] hist_pc;
   logic          hist_flush;
   logic          hist_taken;
   logic [AW-1:0] hist_target;
   logic          invalidate;
   logic          busy;

   riscv_next_btb_strategy #(.ADDR_WIDTH(AW), .ENTRIES(N)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_pm_pc       (pm_pc),
      .i_pm_flush    (pm_flush),
      .o_inject      (inject),
      .o_inject_addr (inject_addr),
      .i_hist_valid  (hist_valid),
      .i_hist_pc     (hist_pc),
      .i_hist_flush  (hist_flush),
      .i_hist_taken  (hist_taken),
      .i_hist_target (hist_target),
      .i_invalidate  (invalidate),
      .o_busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   exp_t exp_q[$];

   // Reference table, indexed and tagged by arithmetic on the PC.
   bit            m_valid [N];
   int            m_tag   [N];
   logic [AW-1:0] m_tgt   [N];
   int            m_ctr   [N];
   int            busy_cnt = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) $display("FAIL %s: got %h expected %h", tag, got, want);
      else n_pass++;
   endtask

   function automatic bit model_hit(input logic [AW-1:0] pc, input bit need_ctr);
      int i;
      bit h;
      i = (int'(pc) >> 2) % N;
      h = m_valid[i] && (m_tag[i] == (int'(pc) >> 7));
      if (need_ctr) h = h && (m_ctr[i] >= 2);
      return h;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
   endtask

   task automatic step(input string tag, input logic [AW-1:0] lpc, input bit lflush,
                       input bit hv, input logic [AW-1:0] hpc, input bit hfl, input bit htk,
                       input logic [AW-1:0] htgt, input bit inv, input bit r);
      exp_t e, got;
      bit   cur_busy, use_ctr;
      int   li, hi;
`ifdef RISCV_NEXT_BTB_COUNTER_EN
      use_ctr = 1'b1;
`else
      use_ctr = 1'b0;
`endif
      rst = r; pm_pc = lpc; pm_flush = lflush;
      hist_valid = hv; hist_pc = hpc; hist_flush = hfl; hist_taken = htk; hist_target = htgt;
      invalidate = inv;

      cur_busy = r || (busy_cnt > 0);
      li = (int'(lpc) >> 2) % N;
      e.busy = cur_busy;
      e.inj  = !cur_busy && !lflush && model_hit(lpc, use_ctr);
      e.addr = e.inj ? m_tgt[li] : '0;
      exp_q.push_back(e);

      @(negedge clk);
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         got = exp_q.pop_front();
         check({tag, "_busy"}, 32'(busy), 32'(got.busy));
         check({tag, "_inject"}, 32'(inject), 32'(got.inj));
         check({tag, "_addr"}, 32'(inject_addr), 32'(got.addr));
      end

      @(posedge clk);
      if (r) begin
         busy_cnt = N;
         clear_model();
      end else begin
         if (hv && !hfl && !cur_busy) begin
            hi = (int'(hpc) >> 2) % N;
            if (use_ctr) begin
               if (model_hit(hpc, 1'b0)) begin
                  if (htk) begin
                     if (m_ctr[hi] < 3) m_ctr[hi]++;
                     m_tgt[hi] = htgt;
                  end else if (m_ctr[hi] > 0) begin
                     m_ctr[hi]--;
                  end
               end else if (htk) begin
                  m_valid[hi] = 1'b1; m_tag[hi] = int'(hpc) >> 7; m_tgt[hi] = htgt; m_ctr[hi] = 2;
               end
            end else begin
               if (htk) begin
                  m_valid[hi] = 1'b1; m_tag[hi] = int'(hpc) >> 7; m_tgt[hi] = htgt;
               end else if (model_hit(hpc, 1'b0)) begin
                  m_valid[hi] = 1'b0;
               end
            end
         end
         if (inv) begin
            busy_cnt = N;
            clear_model();
         end else if (busy_cnt > 0) begin
            busy_cnt--;
         end
      end
      #1;
   endtask

   task automatic look(input string tag, input logic [AW-1:0] pc, input bit fl);
      step(tag, pc, fl, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic train(input string tag, input logic [AW-1:0] pc, input bit tk,
                        input logic [AW-1:0] tgt, input bit hfl);
      step(tag, 16'h0000, 1'b0, 1'b1, pc, hfl, tk, tgt, 1'b0, 1'b0);
   endtask

   task automatic inval(input string tag);
      step(tag, 16'h0100, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
   endtask

   logic [AW-1:0] pool [8] = '{16'h0100, 16'h0180, 16'h0104, 16'h0200,
                              16'h1100, 16'h007c, 16'hfffc, 16'h0108};

   initial begin
      rst = 1'b1; pm_pc = '0; pm_flush = 1'b0; hist_valid = 1'b0; hist_pc = '0;
      hist_flush = 1'b0; hist_taken = 1'b0; hist_target = '0; invalidate = 1'b0;
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = '0; m_ctr[i] = 0;
      end
      #1;

      // Reset: busy for N cycles after deassert, no inject whatever the PC.
      step("reset", 16'h0100, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < N; i++) look("post_reset", 16'($urandom), 1'b0);
      look("idle_after_reset", 16'h0100, 1'b0);

      // Basic train and lookup, plus same-index alias.
      train("train_0100", 16'h0100, 1'b1, 16'h0240, 1'b0);
      look("hit_0100", 16'h0100, 1'b0);
      look("alias_0180", 16'h0180, 1'b0);

      // Counter saturation and decay.
      train("tk2", 16'h0100, 1'b1, 16'h0240, 1'b0);
      train("tk3", 16'h0100, 1'b1, 16'h0240, 1'b0);
      train("nt1", 16'h0100, 1'b0, 16'h0000, 1'b0);
      look("after_nt1", 16'h0100, 1'b0);
      train("nt2", 16'h0100, 1'b0, 16'h0000, 1'b0);
      look("after_nt2", 16'h0100, 1'b0);

      // Flush suppression on both paths.
      train("retrain", 16'h0100, 1'b1, 16'h0240, 1'b0);
      train("retrain2", 16'h0100, 1'b1, 16'h0240, 1'b0);
      look("pm_flush", 16'h0100, 1'b1);
      train("hist_flush", 16'h0100, 1'b1, 16'h0300, 1'b1);
      look("keeps_0240", 16'h0100, 1'b0);

      // Invalidate sweep, with a dropped update in the middle.
      inval("inval");
      for (int i = 0; i < N; i++) begin
         if (i == 5) train("drop_busy", 16'h0100, 1'b1, 16'h0500, 1'b0);
         else look("sweep", 16'h0100, 1'b0);
      end
      look("after_sweep", 16'h0100, 1'b0);

      // Restarted sweep.
      train("retrain3", 16'h0100, 1'b1, 16'h0240, 1'b0);
      inval("inval_a");
      for (int i = 0; i < 9; i++) look("sweep_a", 16'h0100, 1'b0);
      inval("inval_restart");
      for (int i = 0; i < N; i++) look("sweep_b", 16'h0100, 1'b0);
      look("after_restart", 16'h0100, 1'b0);

      // Same-cycle update and lookup returns the pre-update entry.
      step("same_cycle", 16'h0104, 1'b0, 1'b1, 16'h0104, 1'b0, 1'b1, 16'h0400, 1'b0, 1'b0);
      look("same_cycle_next", 16'h0104, 1'b0);

      // Reset in the middle of a sweep restarts it.
      inval("inval_c");
      for (int i = 0; i < 6; i++) look("sweep_c", 16'h0104, 1'b0);
      step("mid_reset", 16'h0104, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < N + 1; i++) look("post_mid_reset", 16'h0104, 1'b0);

      // Random mixed traffic over a small PC pool.
      for (int i = 0; i < 300; i++) begin
         step("rand", pool[$urandom_range(7)], ($urandom_range(9) == 0),
              ($urandom_range(1) == 1), pool[$urandom_range(7)], ($urandom_range(9) == 0),
              ($urandom_range(3) != 0), 16'($urandom) & 16'hfffc,
              ($urandom_range(99) == 0), 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/riscv_next_btb_strategy.md
# riscv_next_btb_strategy

Parametrised branch-target-buffer strategy for the `riscv_next` jump predictor, sitting beside the PM-stage and ID-stage injection strategies. It looks up the PM-stage PC each cycle in a direct-mapped, tagged target table and requests an inject of the predicted target. The table is trained from resolved jump/branch history and, unlike the stateless strategies, can be bulk-invalidated (e.g. on `fence.i`) by a sequential sweep.

## Interface
- ADDR_WIDTH, 16, PC/target width
- ENTRIES, 32, table depth; power of two, ≥2; IDX_W = $clog2(ENTRIES); IDX_W+2 < ADDR_WIDTH (elaboration error otherwise)
- i_clk  input  1  clock; all state on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_pm_pc  input  ADDR_WIDTH  lookup PC (PM stage)
- i_pm_flush  input  1  PM stage being flushed; suppresses inject
- o_inject  output  1  predicted-taken hit
- o_inject_addr  output  ADDR_WIDTH  predicted target; 0 when o_inject=0
- i_hist_valid  input  1  resolved control-transfer instruction this cycle
- i_hist_pc  input  ADDR_WIDTH  its PC
- i_hist_flush  input  1  instruction squashed; update suppressed
- i_hist_taken  input  1  resolved taken
- i_hist_target  input  ADDR_WIDTH  resolved target
- i_invalidate  input  1  single-cycle request to clear table
- o_busy  output  1  sweep in progress

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[ADDR_WIDTH-1:IDX_W+2]. Entry = {valid, tag, target, ctr[1:0]}.
- Lookup (combinational from table state): o_inject = !o_busy & !i_pm_flush & valid & tag match & ctr[1]. o_inject_addr = entry target when o_inject, else 0.
- Update when i_hist_valid & !i_hist_flush & !o_busy:
  - Hit, taken: ctr saturating +1 (max 3), target ← i_hist_target.
  - Hit, not taken: ctr saturating −1 (min 0); target unchanged.
  - Miss, taken: allocate/overwrite: valid=1, tag, target, ctr=2 (weakly taken).
  - Miss, not taken: no change.
- Updates arriving while o_busy=1 are dropped.
- FSM states: IDLE, SWEEP. SWEEP clears valid of entry `sweep_idx` per cycle, idx 0..ENTRIES-1, then → IDLE.
  - IDLE & i_invalidate → SWEEP, idx=0.
  - SWEEP & i_invalidate → restart idx=0.
  - Table has a single write port; sweep and update never write in the same cycle.

## Timing
- Reset: FSM ← SWEEP, sweep_idx ← 0. During reset cycle and ENTRIES cycles after deassert, o_busy=1, o_inject=0, o_inject_addr=0.
- Lookup latency 0 cycles. Update written at edge; visible to lookup the following cycle.
- Same-cycle update and lookup at same index: lookup returns pre-update content.
- i_invalidate in IDLE: o_busy rises the next cycle, stays high exactly ENTRIES cycles.
- i_rst mid-sweep: sweep restarts from 0.

## Configuration
- RISCV_NEXT_BTB_COUNTER_EN defined: 2-bit saturating counters as above.
- Undefined: no counter storage; hit condition ignores ctr (valid & tag suffices); not-taken hit clears valid; taken hit/miss writes valid, tag, target.

## Structure
- riscv_next_pkg: btb_entry_t (packed valid/tag/target/ctr; tag/target widths via package-level functions of parameters), btb_state_t enum {BTB_IDLE, BTB_SWEEP}, constants BTB_CTR_INIT=2'd2, BTB_CTR_MAX=2'd3.
- Sub-module riscv_next_btb_sat2: 2-bit saturating up/down counter (combinational next-value).

## Test plan
Defaults (ENTRIES=32: index pc[6:2], tag pc[15:7]), COUNTER_EN defined unless noted.
- Reset 1 cycle → o_busy=1 for 32 cycles then 0; o_inject=0 throughout with any i_pm_pc.
- Update pc=0x0100 taken target 0x0240 → next cycle lookup 0x0100: inject=1, addr=0x0240; lookup 0x0180 (same index, other tag): inject=0, addr=0.
- pc=0x0100 taken×3 then not-taken×1 → inject=1; second not-taken → inject=0. Without COUNTER_EN: inject=0 after first not-taken.
- Trained 0x0100; i_pm_flush=1 → inject=0; update with i_hist_flush=1, target 0x0300 → entry keeps 0x0240.
- Trained 0x0100; i_invalidate pulse → o_busy=1 for 32 cycles, update during sweep dropped; afterwards lookup 0x0100 inject=0. Second i_invalidate at sweep cycle 10 → o_busy lasts 32 cycles from restart.
- Same cycle: update 0x0104 taken 0x0400 and lookup 0x0104 (empty) → inject=0; next cycle inject=1, addr=0x0400.
